// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC spatial-encoder SRAM fetch path.
// Contents:
//   fetch_state_t  - fetch arbiter FSM states
//   NUM_MOD        - number of modality requesters
//   BANKS_PER_MOD  - banks owned by each modality (IM, projM_pos, projM_neg)
//   bank_base()    - index of the first bank owned by a modality
package hdc_pkg;

    localparam int unsigned NUM_MOD       = 3;
    localparam int unsigned BANKS_PER_MOD = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } fetch_state_t;

    function automatic int unsigned bank_base(input int unsigned m);
        return m * BANKS_PER_MOD;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection.
// The search starts one position after last_i and wraps, so the most recent
// winner has the lowest priority.
// Ports:
//   req_i  [NUM_MOD]  request vector
//   last_i [IdxW]     index of the previous winner
//   gnt_o  [NUM_MOD]  one-hot grant (all zero when no request)
//   idx_o  [IdxW]     winner index
//   vld_o             at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_MOD = hdc_pkg::NUM_MOD,
    parameter int unsigned IdxW    = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1
) (
    input  logic [NUM_MOD-1:0] req_i,
    input  logic [IdxW-1:0]    last_i,
    output logic [NUM_MOD-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               vld_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_MOD; k++) begin
            cand = IdxW'((32'(last_i) + k) % NUM_MOD);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdc_sram_fetch_arbiter.sv
// Round-robin controller sharing the single SRAM address bus among the
// modality fetch requesters. One modality is granted at a time: its address
// is driven on the shared bus, its three banks are requested, and once every
// owned bank has returned valid a one-cycle Done_SO pulse goes back to it.
// Optional feature macro: HDC_FETCH_TIMEOUT_EN adds a WAIT watchdog
// (TIMEOUT_CYCLES parameter, Timeout_SO sticky flag).
// Ports:
//   Clk_CI        clock
//   Reset_RI      synchronous reset, active-high
//   Req_SI        per-modality fetch request
//   ReqAddr_DI    per-modality address, modality m at [m*ADDR_WIDTH +: ADDR_WIDTH]
//   Done_SO       one-cycle completion pulse to the granted modality
//   Busy_SO       arbiter not idle
//   SramAddr_DO   shared bank address
//   SramReq_SO    per-bank read request
//   SramValid_SI  per-bank data valid
//   Timeout_SO    sticky watchdog flag (HDC_FETCH_TIMEOUT_EN only)
module hdc_sram_fetch_arbiter #(
    parameter int unsigned NUM_MOD        = hdc_pkg::NUM_MOD,
    parameter int unsigned BANKS_PER_MOD  = hdc_pkg::BANKS_PER_MOD,
    parameter int unsigned ADDR_WIDTH     = 8
`ifdef HDC_FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                              Clk_CI,
    input  logic                              Reset_RI,
    input  logic [NUM_MOD-1:0]                Req_SI,
    input  logic [NUM_MOD*ADDR_WIDTH-1:0]     ReqAddr_DI,
    output logic [NUM_MOD-1:0]                Done_SO,
    output logic                              Busy_SO,
    output logic [ADDR_WIDTH-1:0]             SramAddr_DO,
    output logic [NUM_MOD*BANKS_PER_MOD-1:0]  SramReq_SO,
    input  logic [NUM_MOD*BANKS_PER_MOD-1:0]  SramValid_SI
`ifdef HDC_FETCH_TIMEOUT_EN
    ,
    output logic                              Timeout_SO
`endif
);

    import hdc_pkg::*;

    localparam int unsigned NumBanks = NUM_MOD * BANKS_PER_MOD;
    localparam int unsigned IdxW     = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;

    fetch_state_t               state_q, state_d;
    logic [IdxW-1:0]            win_q, win_d;
    logic [IdxW-1:0]            last_q, last_d;
    logic [BANKS_PER_MOD-1:0]   mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [NumBanks-1:0]        sreq_q, sreq_d;
    logic [NUM_MOD-1:0]         done_q, done_d;
    logic                       busy_q, busy_d;

`ifdef HDC_FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       tmo_q, tmo_d;
`endif

    logic [NUM_MOD-1:0]         arb_gnt;
    logic [IdxW-1:0]            arb_idx;
    logic                       arb_vld;
    logic [ADDR_WIDTH-1:0]      arb_addr;
    logic [BANKS_PER_MOD-1:0]   own_vld;
    logic [BANKS_PER_MOD-1:0]   coll;
    logic                       finish;

    rr_arbiter #(
        .NUM_MOD (NUM_MOD),
        .IdxW    (IdxW)
    ) u_rr (
        .req_i  (Req_SI),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .vld_o  (arb_vld)
    );

    // Address of the winning requester, selected by the one-hot grant.
    always_comb begin
        arb_addr = '0;
        for (int unsigned m = 0; m < NUM_MOD; m++) begin
            if (arb_gnt[m]) begin
                arb_addr = arb_addr | ReqAddr_DI[m*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Only the granted modality's banks count; foreign valids fall off here.
    assign own_vld = BANKS_PER_MOD'(SramValid_SI >> bank_base(32'(win_q)));
    assign coll    = mask_q | own_vld;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        sreq_d  = sreq_q;
        done_d  = '0;
        busy_d  = busy_q;
        finish  = 1'b0;
`ifdef HDC_FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_vld) begin
                    win_d   = arb_idx;
                    addr_d  = arb_addr;
                    sreq_d  = NumBanks'({BANKS_PER_MOD{1'b1}}) << bank_base(32'(arb_idx));
                    busy_d  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Mask restarts here, but a valid already present is kept.
                mask_d  = own_vld;
`ifdef HDC_FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                mask_d = coll;
                finish = &coll;
`ifdef HDC_FETCH_TIMEOUT_EN
                if (!finish) begin
                    if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        finish = 1'b1;
                        tmo_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`endif
                if (finish) begin
                    done_d[win_q] = 1'b1;
                    sreq_d        = '0;
                    state_d       = StDone;
                end
            end
            StDone: begin
                last_d  = win_q;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q <= StIdle;
            win_q   <= '0;
            last_q  <= IdxW'(NUM_MOD - 1);
            mask_q  <= '0;
            addr_q  <= '0;
            sreq_q  <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
`ifdef HDC_FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            sreq_q  <= sreq_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef HDC_FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign Done_SO     = done_q;
    assign Busy_SO     = busy_q;
    assign SramAddr_DO = addr_q;
    assign SramReq_SO  = sreq_q;
`ifdef HDC_FETCH_TIMEOUT_EN
    assign Timeout_SO  = tmo_q;
`endif

endmodule

// File: tb/tb_hdc_sram_fetch_arbiter.sv
// Self-checking bench for hdc_sram_fetch_arbiter: requester and bank
// responder processes, a transaction-level reference model, and directed
// scenarios with literal expectations.
module tb_hdc_sram_fetch_arbiter;

    localparam int NM    = 3;
    localparam int AW    = 8;
    localparam int NB    = 9;
    localparam int NEVER = 1000;
    localparam int TMO   = 4;
`ifdef HDC_FETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] req;
    logic [NM*AW-1:0] raddr;
    logic [NM-1:0] done;
    logic          busy;
    logic [AW-1:0] saddr;
    logic [NB-1:0] sreq;
    logic [NB-1:0] svld;
    logic          tmo;

    always #5 clk = ~clk;

    hdc_sram_fetch_arbiter #(
        .NUM_MOD        (NM),
        .BANKS_PER_MOD  (3),
        .ADDR_WIDTH     (AW)
`ifdef HDC_FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .Clk_CI       (clk),
        .Reset_RI     (rst),
        .Req_SI       (req),
        .ReqAddr_DI   (raddr),
        .Done_SO      (done),
        .Busy_SO      (busy),
        .SramAddr_DO  (saddr),
        .SramReq_SO   (sreq),
        .SramValid_SI (svld)
`ifdef HDC_FETCH_TIMEOUT_EN
        ,
        .Timeout_SO   (tmo)
`endif
    );

`ifndef HDC_FETCH_TIMEOUT_EN
    assign tmo = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Stimulus state, written by the main process at negedges.
    int         want[NM];
    int         served[NM];
    logic [7:0] addr_tab[NM][4];
    int         lat[NB];
    int         age[NB];
    logic [NB-1:0] extra;

    // Requester: holds request and address until its Done pulse, drops next cycle.
    always @(posedge clk) begin
        #1;
        for (int m = 0; m < NM; m++) begin
            req[m] = (want[m] > 0);
            raddr[m*AW +: AW] = addr_tab[m][served[m] % 4];
            if (done[m] === 1'b1 && want[m] > 0) begin
                want[m]--;
                served[m]++;
            end
        end
    end

    // Bank responder: one valid pulse lat[b] cycles after the request rises.
    always @(posedge clk) begin
        logic [NB-1:0] v;
        #1;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            if (sreq[b] === 1'b1) begin
                v[b] = (age[b] == lat[b]);
                age[b]++;
            end else begin
                age[b] = 0;
            end
        end
        svld = v | extra;
    end

    // Reference model: transaction view (grant, issue, collect, complete).
    logic [NM-1:0] m_done;
    logic          m_busy;
    logic [AW-1:0] m_addr;
    logic [NB-1:0] m_req;
    logic          m_tmo;
    int            m_last, m_win, m_t, mc;
    logic [2:0]    m_seen;
    int            m_gnt_log[$];
    logic [NM-1:0] dut_done_log[$];

    always @(posedge clk) begin
        if (rst) begin
            m_done = '0; m_busy = 1'b0; m_addr = '0; m_req = '0; m_tmo = 1'b0;
            m_last = NM - 1; m_win = 0; m_t = 0; m_seen = '0;
        end else if (m_done != '0) begin
            m_done = '0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            for (int k = 1; k <= NM; k++) begin
                mc = (m_last + k) % NM;
                if (!m_busy && req[mc]) begin
                    m_busy = 1'b1;
                    m_win  = mc;
                    m_addr = raddr[mc*AW +: AW];
                    m_req  = 9'(7) << (3 * mc);
                    m_t    = 0;
                    m_seen = '0;
                    m_gnt_log.push_back(mc);
                end
            end
        end else begin
            // m_t is 0 in the issue cycle, then counts wait cycles.
            m_seen |= 3'(svld >> (3 * m_win));
            if (m_t >= 1 && (m_seen == 3'b111 || (TMO_EN && m_t >= TMO))) begin
                if (m_seen != 3'b111) m_tmo = 1'b1;
                m_done = 3'(1 << m_win);
                m_req  = '0;
                m_last = m_win;
            end
            m_t++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (done !== m_done || busy !== m_busy || saddr !== m_addr ||
                sreq !== m_req || tmo !== (TMO_EN ? m_tmo : 1'b0)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t dut done=%b busy=%b addr=%h req=%b tmo=%b; model done=%b busy=%b addr=%h req=%b tmo=%b",
                         $time, done, busy, saddr, sreq, tmo, m_done, m_busy, m_addr, m_req,
                         TMO_EN ? m_tmo : 1'b0);
            end
            if (done != '0) dut_done_log.push_back(done);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int m = 0; m < NM; m++) begin
            want[m]   = 0;
            served[m] = 0;
        end
        for (int b = 0; b < NB; b++) lat[b] = 1;
        extra = '0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (want[0] == 0 && want[1] == 0 && want[2] == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got busy/pending, expected idle within budget");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; raddr = '0; svld = '0;
        for (int m = 0; m < NM; m++)
            for (int k = 0; k < 4; k++) addr_tab[m][k] = '0;
        for (int b = 0; b < NB; b++) age[b] = 0;
        clear_stim();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_addr", 32'(saddr), 32'h0);
        chk("rst_req", 32'(sreq), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);

        // Single request from modality 1, valids one cycle after issue.
        addr_tab[1][0] = 8'h2A;
        want[1] = 1;
        @(negedge clk); chk("single_c0_busy", 32'(busy), 32'h0);
        @(negedge clk); chk("single_c1_addr", 32'(saddr), 32'h2A);
        chk("single_c1_req", 32'(sreq), 32'b000_111_000);
        chk("single_c1_busy", 32'(busy), 32'h1);
        @(negedge clk); chk("single_c2_addr", 32'(saddr), 32'h2A);
        chk("single_c2_req", 32'(sreq), 32'b000_111_000);
        @(negedge clk); chk("single_c3_done", 32'(done), 32'b010);
        chk("single_c3_req", 32'(sreq), 32'h0);
        wait_idle();

        // All three requesting continuously from reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        clear_stim();
        m_gnt_log.delete();
        dut_done_log.delete();
        addr_tab[0][0] = 8'h10; addr_tab[0][1] = 8'h13;
        addr_tab[1][0] = 8'h20; addr_tab[1][1] = 8'h23;
        addr_tab[2][0] = 8'h30; addr_tab[2][1] = 8'h33;
        want[0] = 2; want[1] = 2; want[2] = 2;
        wait_idle();
        chk("rr_count", 32'(dut_done_log.size()), 32'd6);
        if (dut_done_log.size() >= 4) begin
            chk("rr_g0", 32'(dut_done_log[0]), 32'b001);
            chk("rr_g1", 32'(dut_done_log[1]), 32'b010);
            chk("rr_g2", 32'(dut_done_log[2]), 32'b100);
            chk("rr_g3", 32'(dut_done_log[3]), 32'b001);
        end
        for (int i = 1; i < dut_done_log.size(); i++)
            chk("rr_no_repeat", 32'(dut_done_log[i] != dut_done_log[i-1]), 32'h1);
        if (m_gnt_log.size() >= 4) begin
            chk("model_rr_g0", 32'(m_gnt_log[0]), 32'd0);
            chk("model_rr_g1", 32'(m_gnt_log[1]), 32'd1);
            chk("model_rr_g2", 32'(m_gnt_log[2]), 32'd2);
            chk("model_rr_g3", 32'(m_gnt_log[3]), 32'd0);
        end else begin
            chk("model_rr_count", 32'(m_gnt_log.size()), 32'd6);
        end

        // Staggered valids on modality 0 plus a foreign valid on bank 7.
        clear_stim();
        addr_tab[0][0] = 8'h5C;
        lat[0] = 1; lat[1] = 3; lat[2] = 5;
        extra = 9'b010_000_000;
        want[0] = 1;
        repeat (7) @(negedge clk);
        chk("stag_c6_done", 32'(done), 32'h0);
        chk("stag_c6_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("stag_c7_done", 32'(done), 32'b001);
        wait_idle();
        clear_stim();

        // Reset in WAIT: grant 0 completes, grant 1 hangs, reset aborts it.
        addr_tab[0][0] = 8'h44;
        want[0] = 1;
        wait_idle();
        clear_stim();
        addr_tab[1][0] = 8'h55;
        lat[3] = NEVER; lat[4] = NEVER; lat[5] = NEVER;
        want[1] = 1;
        repeat (6) @(negedge clk);
        chk("hang_busy", 32'(busy), 32'h1);
        chk("hang_req", 32'(sreq), 32'b000_111_000);
        rst = 1'b1;
        want[1] = 0;
        @(negedge clk);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_addr", 32'(saddr), 32'h0);
        chk("abort_req", 32'(sreq), 32'h0);
        rst = 1'b0;
        clear_stim();
        addr_tab[0][0] = 8'h66;
        addr_tab[1][0] = 8'h77;
        want[0] = 1; want[1] = 1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (done != '0) begin
                    seen = 1'b1;
                    chk("post_reset_first", 32'(done), 32'b001);
                end
            end
            if (!seen) chk("post_reset_seen", 32'(seen), 32'h1);
        end
        wait_idle();

        // Request held through Done: re-granted at the new address.
        clear_stim();
        addr_tab[2][0] = 8'h11;
        addr_tab[2][1] = 8'h22;
        want[2] = 2;
        @(negedge clk);
        @(negedge clk); chk("regrant_c1_addr", 32'(saddr), 32'h11);
        chk("regrant_c1_req", 32'(sreq), 32'b111_000_000);
        @(negedge clk);
        @(negedge clk); chk("regrant_c3_done", 32'(done), 32'b100);
        @(negedge clk); chk("regrant_c4_busy", 32'(busy), 32'h0);
        chk("regrant_c4_addr_hold", 32'(saddr), 32'h11);
        @(negedge clk); chk("regrant_c5_addr", 32'(saddr), 32'h22);
        chk("regrant_c5_req", 32'(sreq), 32'b111_000_000);
        wait_idle();

`ifdef HDC_FETCH_TIMEOUT_EN
        // Watchdog: bank 2 never answers.
        clear_stim();
        addr_tab[0][0] = 8'h99;
        lat[2] = NEVER;
        want[0] = 1;
        repeat (6) @(negedge clk);
        chk("tmo_c5_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("tmo_c6_done", 32'(done), 32'b001);
        chk("tmo_c6_flag", 32'(tmo), 32'h1);
        wait_idle();
        clear_stim();
        addr_tab[0][0] = 8'hA0;
        want[0] = 1;
        wait_idle();
        chk("tmo_sticky", 32'(tmo), 32'h1);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
